exe_stage_mc: RTL

Parametrised multi-cycle execute stage for the ARM pipeline, sitting between the ID/EX register and the MEM stage. It adds operand forwarding, the registered EX/MEM output, and an iterative shift-add multiplier (MUL/MLA). The multiplier holds the front of the pipeline through a stall handshake until the product is ready.

---
 rtl/exe_pkg.sv | 26 ++
 rtl/mul_iter.sv | 46 ++++
 rtl/exe_stage_mc.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the multi-cycle execute stage: multiplier FSM states,
// forwarding select encodings, ALU command and shift-type codes.
package exe_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: retires RADIX multiplier bits per cycle,
// keeps only the low DATA_W bits of the accumulated product.
module mul_iter #(
  parameter int DATA_W = 32,
  parameter int RADIX  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              run_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] acc_i,
  output logic [DATA_W-1:0] prod_o,
  output logic              done_o
);
  localparam int N     = DATA_W / RADIX;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [DATA_W-1:0] a_q, b_q, acc_q, partial;
  logic [CNT_W-1:0]  cnt_q;

  assign partial = a_q * DATA_W'(b_q[RADIX-1:0]);
  assign done_o  = run_i && (cnt_q == CNT_W'(N - 1));
  assign prod_o  = acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_i;
      cnt_q <= '0;
    end else if (run_i) begin
      // multiplicand walks left as the multiplier digits are consumed from the bottom
      acc_q <= acc_q + partial;
      a_q   <= a_q << RADIX;
      b_q   <= b_q >> RADIX;
      cnt_q <= done_o ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with operand forwarding, registered EX/MEM output and an
// optional iterative MUL/MLA unit enabled by the EXE_MUL_EN macro.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 4,
  parameter int MUL_RADIX_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              is_mul,
  input  logic              mul_acc,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DATA_W-1:0] val_ra,
  input  logic              imm,
  input  logic [11:0]       shift_operand,
  input  logic [23:0]       imm_signed_24,
  input  logic [3:0]        sr,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [1:0]        sel_src_1,
  input  logic [1:0]        sel_src_2,
  input  logic [DATA_W-1:0] mem_val,
  input  logic [DATA_W-1:0] wb_val,
  input  logic              mem_stall,
  output logic              stall,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] br_addr,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [3:0]        status,
  output logic [REG_W-1:0]  dest
);
  localparam int M = DATA_W - 1;

  logic [DATA_W-1:0] src1, src2, val2, imm8, alu_res, prod, br_d, res_d;
  logic [DATA_W:0]   sum;
  logic [4:0]        shamt, rot;
  logic [3:0]        status_d;
  logic              alu_c, alu_v, stall_int, sel_bubble, sel_prod;
  logic              valid_d, wb_d, mr_d, mw_d;

  always_comb begin
    case (sel_src_1)
      FWD_MEM: src1 = mem_val;
      FWD_WB:  src1 = wb_val;
      default: src1 = val_rn;
    endcase
    case (sel_src_2)
      FWD_MEM: src2 = mem_val;
      FWD_WB:  src2 = wb_val;
      default: src2 = val_rm;
    endcase
  end

  assign shamt = shift_operand[11:7];
  assign rot   = {shift_operand[11:8], 1'b0};
  assign imm8  = DATA_W'(shift_operand[7:0]);

  always_comb begin
    val2 = src2;
    if (mem_r_en_in || mem_w_en_in)
      val2 = DATA_W'(shift_operand);
    else if (imm)
      val2 = (imm8 >> rot) | (imm8 << (DATA_W - rot));
    else begin
      case (shift_operand[6:5])
        SH_LSL: val2 = src2 << shamt;
        SH_LSR: val2 = src2 >> shamt;
        SH_ASR: val2 = DATA_W'($signed(src2) >>> shamt);
        SH_ROR: val2 = (src2 >> shamt) | (src2 << (DATA_W - shamt));
        default: val2 = src2;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    alu_c   = sr[1];
    alu_v   = sr[0];
    sum     = '0;
    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, src1} + {1'b0, val2}
                + ((exe_cmd == CMD_ADC) ? (DATA_W+1)'(sr[1]) : '0);
        alu_res = sum[M:0];
        alu_c   = sum[DATA_W];
        alu_v   = (src1[M] == val2[M]) && (alu_res[M] != src1[M]);
      end
      CMD_SUB, CMD_SBC: begin
        // carry out is the ARM "no borrow" flag
        sum     = {1'b0, src1} - {1'b0, val2}
                - ((exe_cmd == CMD_SBC) ? (DATA_W+1)'(~sr[1]) : '0);
        alu_res = sum[M:0];
        alu_c   = ~sum[DATA_W];
        alu_v   = (src1[M] != val2[M]) && (alu_res[M] != src1[M]);
      end
      CMD_AND: alu_res = src1 & val2;
      CMD_ORR: alu_res = src1 | val2;
      CMD_EOR: alu_res = src1 ^ val2;
      default: alu_res = '0;
    endcase
  end

  assign br_d = pc_in + {{(DATA_W-26){imm_signed_24[23]}}, imm_signed_24, 2'b00};

`ifdef EXE_MUL_EN
  mul_state_e state_q, state_d;
  logic       mul_start, mul_run, mul_done;

  mul_iter #(.DATA_W(DATA_W), .RADIX(MUL_RADIX_BITS)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mul_start),
    .run_i   (mul_run),
    .a_i     (src1),
    .b_i     (src2),
    .acc_i   (mul_acc ? val_ra : '0),
    .prod_o  (prod),
    .done_o  (mul_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mul_start  = 1'b0;
    mul_run    = 1'b0;
    stall_int  = 1'b0;
    sel_bubble = 1'b0;
    sel_prod   = 1'b0;
    case (state_q)
      IDLE: if (in_valid && is_mul) begin
        stall_int  = 1'b1;
        sel_bubble = 1'b1;
        if (!mem_stall) begin
          mul_start = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_int  = 1'b1;
        sel_bubble = 1'b1;
        mul_run    = 1'b1;
        if (mul_done) state_d = DONE;
      end
      // the MUL still on the inputs here is the one just finished, never restarted
      DONE: begin
        sel_prod = 1'b1;
        if (!mem_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  logic unused_mul;
  localparam int unused_radix = MUL_RADIX_BITS;
  assign unused_mul = ^{is_mul, mul_acc, val_ra};
  assign stall_int  = 1'b0;
  assign sel_bubble = 1'b0;
  assign sel_prod   = 1'b0;
  assign prod       = '0;
`endif

  assign stall = (rst & stall_int) | mem_stall;

  always_comb begin
    valid_d  = in_valid;
    wb_d     = wb_en_in;
    mr_d     = mem_r_en_in;
    mw_d     = mem_w_en_in;
    res_d    = alu_res;
    status_d = {alu_res[M], ~|alu_res, alu_c, alu_v};
    if (sel_prod) begin
      res_d    = prod;
      status_d = {prod[M], ~|prod, sr[1:0]};
    end
    if (sel_bubble) {valid_d, wb_d, mr_d, mw_d} = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {out_valid, wb_en, mem_r_en, mem_w_en} <= '0;
      alu_result <= '0;
      br_addr    <= '0;
      val_rm_out <= '0;
      status     <= '0;
      dest       <= '0;
    end else if (!mem_stall) begin
      {out_valid, wb_en, mem_r_en, mem_w_en} <= {valid_d, wb_d, mr_d, mw_d};
      alu_result <= res_d;
      br_addr    <= br_d;
      val_rm_out <= src2;
      status     <= status_d;
      dest       <= dest_in;
    end
  end
endmodule
